// File: rtl/atm_pkg.sv
// Shared op-codes and FSM encoding for the ATM ledger controller.
// Pure definitions: no logic, no latency, no flow control.
package atm_pkg;

  localparam logic [1:0] OP_DEPOSIT  = 2'b00;
  localparam logic [1:0] OP_BALANCE  = 2'b01;
  localparam logic [1:0] OP_WITHDRAW = 2'b10;
  localparam logic [1:0] OP_RSVD     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit at or after ptr, wrapping; one-hot result.
// Purely combinational (0 cycles); no backpressure, an empty req gives winner=0.
module rr_arbiter #(
  parameter int N = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner
);

  int            idx;
  logic [PW-1:0] sel;
  logic          found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      sel = PW'(idx);
      if (!found && req[sel]) begin
        winner[sel] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// Round-robin shared ledger: grant at +0, ledger update at +1, done+flags at +2.
// Requesters hold req until done; only one transaction is in flight at a time.
module atm_ledger_arbiter
  import atm_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int W        = 6,
  parameter int INIT_BAL = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] op,
  input  logic [W*N_REQ-1:0] amount,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic               success,
  output logic               nobalance,
  output logic               overflow,
  output logic [W-1:0]       balance,
  output logic               busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q;
  logic [N_REQ-1:0] winner_c;
  logic [PW-1:0]    win_idx_c, win_idx_q;
  logic [1:0]       op_c, op_q;
  logic [W-1:0]     amt_c, amt_q;
  logic [W-1:0]     ledger_q;
  logic [W:0]       sum_c, diff_c;
  logic [N_REQ-1:0] grant_q, done_q;
  logic             pend_succ_q, pend_nob_q, pend_ovf_q;
  logic             success_q, nobalance_q, overflow_q;
  logic             capture, execute, respond;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner_c)
  );

  always_comb begin
    op_c      = '0;
    amt_c     = '0;
    win_idx_c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner_c[i]) begin
        op_c      = op[2*i +: 2];
        amt_c     = amount[W*i +: W];
        win_idx_c = PW'(i);
      end
    end
  end

  // One extra bit catches both deposit carry-out and withdraw borrow.
  assign sum_c  = {1'b0, ledger_q} + {1'b0, amt_q};
  assign diff_c = {1'b0, ledger_q} - {1'b0, amt_q};

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|req) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    capture = (state_q == ST_IDLE) && (|req);
    execute = (state_q == ST_EXEC);
    respond = (state_q == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      ledger_q    <= W'(INIT_BAL);
      grant_q     <= '0;
      done_q      <= '0;
      win_idx_q   <= '0;
      op_q        <= OP_DEPOSIT;
      amt_q       <= '0;
      pend_succ_q <= 1'b0;
      pend_nob_q  <= 1'b0;
      pend_ovf_q  <= 1'b0;
      success_q   <= 1'b0;
      nobalance_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      done_q      <= '0;
      success_q   <= 1'b0;
      nobalance_q <= 1'b0;
      overflow_q  <= 1'b0;

      if (capture) begin
        grant_q   <= winner_c;
        win_idx_q <= win_idx_c;
        op_q      <= op_c;
        amt_q     <= amt_c;
      end

      if (execute) begin
        pend_succ_q <= 1'b0;
        pend_nob_q  <= 1'b0;
        pend_ovf_q  <= 1'b0;
        case (op_q)
          OP_DEPOSIT: begin
            if (sum_c[W]) begin
              pend_ovf_q <= 1'b1;
            end else begin
              ledger_q    <= sum_c[W-1:0];
              pend_succ_q <= 1'b1;
            end
          end
          OP_BALANCE: pend_succ_q <= 1'b1;
          OP_WITHDRAW: begin
            if (diff_c[W]) begin
              pend_nob_q <= 1'b1;
            end else begin
              ledger_q    <= diff_c[W-1:0];
              pend_succ_q <= 1'b1;
            end
          end
          OP_RSVD: ;
          default: ;
        endcase
      end

      // Flags leave together with done; the ledger already holds the result.
      if (respond) begin
        done_q      <= grant_q;
        success_q   <= pend_succ_q;
        nobalance_q <= pend_nob_q;
        overflow_q  <= pend_ovf_q;
        grant_q     <= '0;
        ptr_q       <= (win_idx_q == PW'(N_REQ - 1)) ? '0 : win_idx_q + 1'b1;
      end
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign success   = success_q;
  assign nobalance = nobalance_q;
  assign overflow  = overflow_q;
  assign balance   = ledger_q;

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Scoreboard bench: driver pushes model results per batch, monitor checks each done.
module tb_atm_ledger_arbiter;

  localparam int N    = 4;
  localparam int W    = 6;
  localparam int INIT = 0;
  localparam int MAXV = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [2*N-1:0] op;
  logic [W*N-1:0] amount;
  logic [N-1:0]   grant, done;
  logic           success, nobalance, overflow, busy;
  logic [W-1:0]   balance;

  atm_ledger_arbiter #(.N_REQ(N), .W(W), .INIT_BAL(INIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .amount    (amount),
    .grant     (grant),
    .done      (done),
    .success   (success),
    .nobalance (nobalance),
    .overflow  (overflow),
    .balance   (balance),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int idx;
    int succ;
    int nob;
    int ovf;
    int bal;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   m_bal;
  int   m_ptr;

  int b_op[N];
  int b_amt[N];
  int b_cnt[N];
  bit b_early[N];

  task automatic chk(string name, int act, int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic clear_b();
    for (int i = 0; i < N; i++) begin
      b_op[i] = 0; b_amt[i] = 0; b_cnt[i] = 0; b_early[i] = 1'b0;
    end
  endtask

  task automatic add(int i, int o, int a, int c, bit e);
    b_op[i] = o; b_amt[i] = a; b_cnt[i] = c; b_early[i] = e;
  endtask

  // Reference: serve pending terminals in round-robin order from the model pointer.
  task automatic model_batch(int start);
    int   rem[N];
    int   j;
    int   w;
    exp_t e;
    for (int i = 0; i < N; i++) rem[i] = b_cnt[i];
    j = 0;
    forever begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && rem[(m_ptr + k) % N] > 0) w = (m_ptr + k) % N;
      end
      if (w < 0) break;
      e.idx = w; e.succ = 0; e.nob = 0; e.ovf = 0;
      case (b_op[w])
        0: if (m_bal + b_amt[w] > MAXV) e.ovf = 1;
           else begin m_bal = m_bal + b_amt[w]; e.succ = 1; end
        1: e.succ = 1;
        2: if (b_amt[w] > m_bal) e.nob = 1;
           else begin m_bal = m_bal - b_amt[w]; e.succ = 1; end
        default: ;
      endcase
      e.bal = m_bal;
      e.cyc = start + 2 + 3 * j;
      sbq.push_back(e);
      j++;
      rem[w]--;
      m_ptr = (w + 1) % N;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_bal = INIT;
    m_ptr = 0;
  endtask

  task automatic run_batch();
    int seen[N];
    int total;
    int got;
    chk("idle_balance", int'(balance), m_bal);
    total = 0;
    for (int i = 0; i < N; i++) begin
      seen[i] = 0;
      total += b_cnt[i];
      if (b_cnt[i] > 0) begin
        op[2*i +: 2]     = 2'(b_op[i]);
        amount[W*i +: W] = W'(b_amt[i]);
        req[i]           = 1'b1;
      end
    end
    model_batch(cyc + 1);
    got = 0;
    for (int t = 0; t < 3 * total + 10 && got < total; t++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          seen[i]++;
          got++;
          if (seen[i] >= b_cnt[i]) req[i] = 1'b0;
        end
        if (grant[i]) begin
          if (b_early[i]) req[i] = 1'b0;
          // Captured operands must not follow later input changes.
          if (seen[i] == b_cnt[i] - 1) begin
            op[2*i +: 2]     = 2'($urandom);
            amount[W*i +: W] = W'($urandom);
          end
        end
      end
    end
    chk("batch_done_count", got, total);
    req = '0;
    repeat (2) @(negedge clk);
    if (got < total) begin
      sbq.delete();
      do_reset();
    end
  endtask

  initial begin
    exp_t       e;
    logic [N-1:0] pg;
    pg = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (grant != '0 && pg == '0 && sbq.size() > 0) begin
          chk("grant_owner", int'(grant), 1 << sbq[0].idx);
          chk("busy_while_granted", int'(busy), 1);
        end
        if (done != '0) begin
          if (sbq.size() == 0) begin
            chk("unexpected_done", int'(done), 0);
          end else begin
            e = sbq.pop_front();
            chk("done_owner", int'(done), 1 << e.idx);
            chk("success", int'(success), e.succ);
            chk("nobalance", int'(nobalance), e.nob);
            chk("overflow", int'(overflow), e.ovf);
            chk("balance", int'(balance), e.bal);
            chk("done_cycle", cyc, e.cyc);
          end
        end
      end
      pg = grant;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int mask;
    int c;
    rst    = 1'b1;
    req    = '0;
    op     = '0;
    amount = '0;
    do_reset();

    chk("rst_grant", int'(grant), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_success", int'(success), 0);
    chk("rst_nobalance", int'(nobalance), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_balance", int'(balance), INIT);

    clear_b(); add(0, 0, 34, 1, 0); run_batch();
    clear_b(); add(1, 2, 51, 1, 0); run_batch();
    clear_b(); add(1, 2, 34, 1, 0); run_batch();
    clear_b(); add(2, 0, 60, 1, 0); run_batch();
    clear_b(); add(3, 0, 3, 1, 0);  run_batch();
    clear_b(); add(0, 0, 1, 1, 0);  run_batch();
    clear_b(); add(3, 1, 0, 1, 0);  run_batch();

    clear_b();
    add(0, 2, 10, 2, 0); add(1, 1, 0, 1, 0); add(2, 2, 20, 1, 0); add(3, 0, 0, 1, 0);
    run_batch();

    clear_b(); add(2, 2, 5, 1, 1); run_batch();
    clear_b(); add(1, 3, 7, 1, 0); run_batch();

    // Abandon a transaction while it is executing.
    op[6 +: 2]     = 2'b00;
    amount[18 +: 6] = 6'd9;
    req[3]         = 1'b1;
    t = 0;
    while (!grant[3] && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("midexec_grant_seen", int'(grant[3]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    m_bal = INIT;
    m_ptr = 0;
    chk("midexec_grant", int'(grant), 0);
    chk("midexec_done", int'(done), 0);
    chk("midexec_busy", int'(busy), 0);
    chk("midexec_flags", int'({success, nobalance, overflow}), 0);
    chk("midexec_balance", int'(balance), INIT);
    repeat (4) @(negedge clk);

    clear_b();
    for (int i = 0; i < N; i++) add(i, 0, 1, 1, 0);
    run_batch();

    for (int b = 0; b < 40; b++) begin
      clear_b();
      mask = $urandom_range(1, (1 << N) - 1);
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          c = $urandom_range(1, 2);
          add(i, $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, MAXV),
              c, (c == 1) && ($urandom_range(0, 3) == 0));
        end
      end
      run_batch();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/atm_ledger_arbiter.md
# atm_ledger_arbiter

Shared-account controller that lets up to N_REQ ATM front-end terminals take turns at a single account balance register. A round-robin arbiter grants one terminal at a time. The block then executes that terminal's deposit, balance-check or withdraw operation against the ledger and returns a one-cycle completion pulse with result flags. It sits between the per-terminal ATM state machines and the account store, replacing each terminal's private balance.

## Interface
- N_REQ, 4, number of terminals (2..8)
- W, 6, amount/balance width in bits
- INIT_BAL, 0, balance value loaded at reset
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  N_REQ  per-terminal request, level; held until that terminal's done
- op  input  2*N_REQ  per-terminal operation, slice i = op[2i+1:2i]; 00 deposit, 01 balance check, 10 withdraw, 11 reserved
- amount  input  W*N_REQ  per-terminal amount, slice i = amount[W*i+W-1:W*i]
- grant  output  N_REQ  one-hot (or zero) owner of the ledger
- done  output  N_REQ  one-cycle completion pulse to the owner
- success  output  1  valid while done≠0: operation applied
- nobalance  output  1  valid while done≠0: withdraw exceeded balance
- overflow  output  1  valid while done≠0: deposit would exceed 2^W−1
- balance  output  W  ledger value after the operation; valid while done≠0, otherwise current ledger
- busy  output  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE, no req: stay in IDLE, grant=0.
- IDLE, any req bit set: pick the winner with round-robin, starting the search at ptr and wrapping. Register grant as one-hot of the winner. Capture the winner's op and amount into internal registers. Go to EXEC.
- EXEC, deposit: if ledger+amount > 2^W−1, ledger is unchanged, overflow=1, success=0. Otherwise ledger += amount, success=1.
- EXEC, balance check: ledger unchanged, success=1.
- EXEC, withdraw: if amount > ledger, ledger is unchanged, nobalance=1, success=0. Otherwise ledger −= amount, success=1.
  - amount == ledger is legal and gives ledger 0.
- EXEC, op 11: no change; success, nobalance and overflow all 0.
- EXEC, in all cases: go to RESP.
- RESP: done = grant for exactly one cycle, then clear grant, set ptr = winner+1 mod N_REQ, return to IDLE.
- Arithmetic: compute with a W+1-bit sum or difference. The ledger never wraps.
- Amount 0: deposit and withdraw both succeed with no change.
- Captured operands are final. Changes to req, op or amount after the IDLE capture edge do not affect the transaction in flight, including req dropping early.
- Flags are mutually exclusive and are registered together with done.

## Timing
- Reset values:
  - state=IDLE, ptr=0, ledger=INIT_BAL
  - grant=0, done=0, busy=0
  - success=0, nobalance=0, overflow=0
- Latency: req sampled high at edge k gives grant high from edge k, the ledger update at edge k+1, and done plus flags high for the cycle after edge k+2. That is 3 cycles per transaction.
- Requester protocol: deassert req in the cycle done is seen. A req still high at the following edge is a new transaction.
- Back-to-back: the next grant can be registered at the edge right after the RESP cycle. Peak throughput is one transaction per 3 cycles.
- Simultaneous requests: resolved strictly round-robin from ptr, so no terminal waits more than N_REQ−1 transactions.
- Reset mid-transaction: the in-flight operation is abandoned. The ledger returns to INIT_BAL and there is no done pulse.

## Structure
- The shared package atm_pkg holds:
  - op-code localparams OP_DEPOSIT, OP_BALANCE, OP_WITHDRAW, OP_RSVD
  - the FSM state encoding
- Sub-module rr_arbiter: combinational, with inputs req[N_REQ] and ptr, and output one-hot winner. It is reusable by other shared-resource controllers.
- Ledger arithmetic and the FSM stay in atm_ledger_arbiter.

## Test plan
- Single deposit: reset with INIT_BAL=0. Terminal 0 deposits 34. Expect grant[0] at +0, done[0] at +2 with success=1 and balance=34.
- Overdraw: with ledger 34, terminal 1 withdraws 51. Expect nobalance=1, success=0, balance stays 34. Then it withdraws 34: success=1, balance=0.
- Overflow boundary: ledger 60, deposit 3 gives balance 63 and success. A further deposit of 1 gives overflow=1 and balance 63.
- Fairness: all 4 req held continuously. Expect grant order 0,1,2,3,0 with exactly 3 cycles between done pulses and no done missing.
- Early drop and reserved op: terminal 2 drops req one cycle after grant. Its withdraw of 5 still completes with done[2]. Op 11 returns all flags 0 with the ledger unchanged.
- Reset mid-EXEC: assert rst during EXEC. Expect no done, all outputs at reset values, balance=INIT_BAL, and the next grant to go to terminal 0.
